cam_query_sequencer: RTL and testbench
======================================

# cam_query_sequencer

Command front-end for the 16x8 content-addressable memory. Accepts insert and search commands over a valid/ready handshake and allocates CAM addresses sequentially for inserts. Drives the CAM write/read strobes, key and address, and returns each result (hit flag plus matching or allocated address) over a second valid/ready handshake. Sits directly upstream of the CAM and is its only driver.

## Interface
- DATA_W, 8, key width; equals CAM din width
- ADDR_W, 4, CAM address width
- DEPTH, 16, number of CAM entries; equals 2**ADDR_W

- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  1  0 = insert, 1 = search
- cmd_key  in  DATA_W  key to insert or search
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_hit  out  1  search matched, or insert succeeded
- rsp_addr  out  ADDR_W  matched address (search) or written address (insert)
- entry_count  out  ADDR_W+1  entries allocated, 0..DEPTH
- full  out  1  entry_count == DEPTH
- cam_wen  out  1  CAM write enable
- cam_ren  out  1  CAM read (search) enable
- cam_din  out  DATA_W  CAM key/data
- cam_addr  out  ADDR_W  CAM write address
- cam_dout  in  ADDR_W  CAM matched address, registered; valid the cycle after the ren sample edge
- cam_hit  in  1  CAM hit flag, same timing as cam_dout

## Operation
- States: IDLE, WRITE, READ, WAIT, RESP.
- IDLE:
  - cmd_ready = 1. All cam_* outputs are 0.
  - On cmd_valid & cmd_ready, latch op and key.
  - Insert with full = 0: go to WRITE.
  - Insert with full = 1: go to RESP with rsp_hit = 0 and rsp_addr = 0. No CAM access.
  - Search: go to READ.
- WRITE: one cycle.
  - cam_wen = 1, cam_addr = entry_count[ADDR_W-1:0], cam_din = key.
  - On exit: entry_count += 1, rsp_hit = 1, rsp_addr = written address. Go to RESP.
- READ: one cycle with cam_ren = 1 and cam_din = key. Go to WAIT.
- WAIT: one cycle.
  - Capture rsp_hit = cam_hit & (cam_dout < entry_count), and rsp_addr = cam_dout if hit, else 0.
  - The mask suppresses stale CAM contents, because the CAM is not cleared by rst.
  - Go to RESP.
- RESP: rsp_valid = 1. rsp_hit and rsp_addr are held stable until rsp_ready. Go to IDLE on the handshake edge.
- cam_wen and cam_ren are never both 1. At most one command is in flight.
- There is no deletion and no wrap-around. Once full, inserts are rejected until rst.
- Duplicate keys are not checked. A search returns whatever the CAM reports; the CAM gives the highest matching address.
- rsp_* are registered. cmd_ready = (state == IDLE) & ~rst.

## Timing
- Reset, at the rst posedge:
  - state = IDLE, entry_count = 0.
  - rsp_valid = 0, rsp_hit = 0, rsp_addr = 0.
  - cam_wen = 0, cam_ren = 0, cam_din = 0, cam_addr = 0.
  - full = 0. cmd_ready is 0 while rst = 1 and 1 in the first cycle after release.
- Latency is counted from the command-accept edge E0 to the first cycle with rsp_valid = 1:
  - search: 3 cycles
  - successful insert: 2 cycles
  - rejected insert: 1 cycle
- Command throughput with rsp_ready tied high:
  - search: one per 4 cycles
  - insert: one per 3 cycles
  - rejected insert: one per 2 cycles
- Response backpressure: rsp_valid stays high and no new command is accepted while rsp_ready = 0.
- entry_count and full update on the WRITE exit edge, which is the same edge on which the CAM samples the write.
- rst mid-operation (any state) takes effect at that edge:
  - The pending response is dropped.
  - A WRITE in progress at that edge still reaches the CAM, but entry_count returns to 0.

## Test plan
- Reset, then insert keys 4, 8, 35, 8 -> responses hit=1 at addr 0, 1, 2, 3; entry_count=4; cam_wen pulses once per insert with the matching cam_addr and cam_din.
- Search 4, 8, 35, 87, 45 after the inserts above -> (hit=1, addr 0), (hit=1, addr 3), (hit=1, addr 2), (hit=0, addr 0), (hit=0, addr 0); each rsp_valid appears exactly 3 cycles after acceptance.
- Insert keys 1..16 -> full=1 after the 16th; a 17th insert (key 99) -> hit=0, addr 0 after 1 cycle, no cam_wen pulse, entry_count stays 16.
- Hold rsp_ready=0 for 5 cycles during a search response -> rsp_valid, rsp_hit and rsp_addr are held; cmd_ready=0 throughout; the next command is accepted only after the rsp handshake.
- Insert 4 at addr 0, pulse rst, then search 4 -> the CAM reports a hit at addr 0 but entry_count=0, so the response is hit=0, addr 0.
- Assert rst while in WAIT -> no rsp_valid; next cycle state is IDLE and cmd_ready=1 after release; cam_wen and cam_ren are never simultaneously 1 across all scenarios.

Source files
------------

// File: rtl/cam_query_sequencer_if.sv
// Command and response handshake bundle between a requester and the CAM query sequencer.
interface cam_query_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [DATA_W-1:0] cmd_key;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_hit;
    logic [ADDR_W-1:0] rsp_addr;

    modport master (
        output cmd_valid, cmd_op, cmd_key, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_hit, rsp_addr
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_key, rsp_ready,
        output cmd_ready, rsp_valid, rsp_hit, rsp_addr
    );
endinterface

// File: rtl/cam_query_sequencer.sv
// Front-end for a 16x8 CAM: sequential-address inserts, masked searches, one command in flight,
// result returned on a registered valid/ready response channel.
module cam_query_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic                clk,
    input  logic                rst,
    cam_query_sequencer_if.slave bus,
    output logic [ADDR_W:0]     entry_count,
    output logic                full,
    output logic                cam_wen,
    output logic                cam_ren,
    output logic [DATA_W-1:0]   cam_din,
    output logic [ADDR_W-1:0]   cam_addr,
    input  logic [ADDR_W-1:0]   cam_dout,
    input  logic                cam_hit
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        WAIT,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   key_q, key_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                rsp_hit_q, rsp_hit_d;
    logic [ADDR_W-1:0]   rsp_addr_q, rsp_addr_d;
    logic                search_hit;

    // The CAM survives rst, so a match at or above the allocation point is stale data.
    assign search_hit = cam_hit && ({1'b0, cam_dout} < count_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            key_q      <= '0;
            count_q    <= '0;
            rsp_hit_q  <= 1'b0;
            rsp_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            count_q    <= count_d;
            rsp_hit_q  <= rsp_hit_d;
            rsp_addr_q <= rsp_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        count_d    = count_q;
        rsp_hit_d  = rsp_hit_q;
        rsp_addr_d = rsp_addr_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && bus.cmd_ready) begin
                    key_d = bus.cmd_key;
                    if (bus.cmd_op) begin
                        state_d = READ;
                    end else if (full) begin
                        rsp_hit_d  = 1'b0;
                        rsp_addr_d = '0;
                        state_d    = RESP;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                count_d    = count_q + (ADDR_W+1)'(1);
                rsp_hit_d  = 1'b1;
                rsp_addr_d = count_q[ADDR_W-1:0];
                state_d    = RESP;
            end
            READ: begin
                state_d = WAIT;
            end
            WAIT: begin
                rsp_hit_d  = search_hit;
                rsp_addr_d = search_hit ? cam_dout : '0;
                state_d    = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = (state_q == IDLE) && !rst;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_hit   = rsp_hit_q;
    assign bus.rsp_addr  = rsp_addr_q;

    // Strobes decode straight from the state register, so they are mutually exclusive by construction.
    assign cam_wen  = (state_q == WRITE);
    assign cam_ren  = (state_q == READ);
    assign cam_din  = (cam_wen || cam_ren) ? key_q : '0;
    assign cam_addr = cam_wen ? count_q[ADDR_W-1:0] : '0;

    assign entry_count = count_q;
    assign full        = (count_q == (ADDR_W+1)'(DEPTH));

endmodule

// File: tb/tb_cam_query_sequencer.sv
// Directed plus randomized bench for cam_query_sequencer with a behavioural CAM and a
// list-based reference model of allocation and search masking.
module tb_cam_query_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  entry_count;
    logic        full;
    logic        cam_wen;
    logic        cam_ren;
    logic [7:0]  cam_din;
    logic [3:0]  cam_addr;
    logic [3:0]  cam_dout_r = 4'd0;
    logic        cam_hit_r  = 1'b0;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // behavioural CAM: contents persist across rst, highest matching address wins
    logic [7:0]  cmem [16];
    logic        cvld [16] = '{default: 1'b0};
    logic [11:0] wen_log [$];
    logic        both_seen = 1'b0;

    // reference model: what was written where, and how many entries are live since reset
    logic [7:0]  model_mem [16];
    logic        model_wr  [16] = '{default: 1'b0};
    int          model_cnt = 0;

    cam_query_sequencer_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    cam_query_sequencer #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .entry_count (entry_count),
        .full        (full),
        .cam_wen     (cam_wen),
        .cam_ren     (cam_ren),
        .cam_din     (cam_din),
        .cam_addr    (cam_addr),
        .cam_dout    (cam_dout_r),
        .cam_hit     (cam_hit_r)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] cam_lookup(input logic [7:0] k);
        logic       h;
        logic [3:0] a;
        h = 1'b0;
        a = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (cvld[i] && cmem[i] == k) begin
                h = 1'b1;
                a = 4'(i);
            end
        end
        return {h, a};
    endfunction

    always @(posedge clk) begin
        if (cam_wen) begin
            cmem[cam_addr] <= cam_din;
            cvld[cam_addr] <= 1'b1;
            wen_log.push_back({cam_addr, cam_din});
        end
        if (cam_ren) begin
            {cam_hit_r, cam_dout_r} <= cam_lookup(cam_din);
        end
        if (cam_wen && cam_ren) begin
            both_seen <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        rst = 1'b0;
        model_cnt = 0;
        @(negedge clk);
        chk("rst_ready_after", 32'(bus.cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_hit", 32'(bus.rsp_hit), 32'd0);
        chk("rst_rsp_addr", 32'(bus.rsp_addr), 32'd0);
        chk("rst_entry_count", 32'(entry_count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_cam_strobes", 32'({cam_wen, cam_ren}), 32'd0);
        chk("rst_cam_din_addr", 32'({cam_din, cam_addr}), 32'd0);
        $display("reset applied");
    endtask

    task automatic do_cmd(input logic op, input logic [7:0] key, input int hold);
        logic       exp_hit;
        logic [3:0] exp_addr;
        logic [11:0] last_wr;
        int         exp_lat;
        int         lat;
        int         wen0;
        int         guard;
        int         wr;
        wr = 0;
        if (!op) begin
            if (model_cnt == 16) begin
                exp_hit = 1'b0; exp_addr = 4'd0; exp_lat = 1;
            end else begin
                exp_hit = 1'b1; exp_addr = 4'(model_cnt); exp_lat = 2; wr = 1;
                model_mem[model_cnt] = key;
                model_wr[model_cnt]  = 1'b1;
                model_cnt++;
            end
        end else begin
            exp_hit = 1'b0; exp_addr = 4'd0; exp_lat = 3;
            for (int a = 0; a < 16; a++) begin
                if (model_wr[a] && model_mem[a] == key) begin
                    exp_hit  = (a < model_cnt);
                    exp_addr = (a < model_cnt) ? 4'(a) : 4'd0;
                end
            end
        end
        wen0 = wen_log.size();
        guard = 0;
        while (!bus.cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("cmd_ready", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_key   = key;
        bus.rsp_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        $display("%s key=%0d -> hit=%0d addr=%0d lat=%0d (model hit=%0d addr=%0d lat=%0d)",
                 op ? "search" : "insert", key, bus.rsp_hit, bus.rsp_addr, lat,
                 exp_hit, exp_addr, exp_lat);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rsp_hit", 32'(bus.rsp_hit), 32'(exp_hit));
        chk("rsp_addr", 32'(bus.rsp_addr), 32'(exp_addr));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_hit_addr", 32'({bus.rsp_hit, bus.rsp_addr}), 32'({exp_hit, exp_addr}));
            chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        if (hold > 0) begin
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            chk("released", 32'(bus.rsp_valid), 32'd0);
        end
        chk("wen_pulses", 32'(wen_log.size() - wen0), 32'(wr));
        if (wr != 0) begin
            last_wr = wen_log[wen_log.size() - 1];
            chk("wr_cam_addr", 32'(last_wr[11:8]), 32'(exp_addr));
            chk("wr_cam_din", 32'(last_wr[7:0]), 32'(key));
        end
        chk("entry_count", 32'(entry_count), 32'(model_cnt));
        chk("full", 32'(full), 32'(model_cnt == 16));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rkey;
        logic       rop;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_key   = 8'd0;
        bus.rsp_ready = 1'b1;
        do_reset();

        // basic inserts, including a duplicate key
        do_cmd(1'b0, 8'd4, 0);
        do_cmd(1'b0, 8'd8, 0);
        do_cmd(1'b0, 8'd35, 0);
        do_cmd(1'b0, 8'd8, 0);
        chk("count_after_4", 32'(entry_count), 32'd4);

        // searches: the duplicate resolves to its highest address
        do_cmd(1'b1, 8'd4, 0);
        do_cmd(1'b1, 8'd8, 0);
        do_cmd(1'b1, 8'd35, 0);
        do_cmd(1'b1, 8'd87, 0);
        do_cmd(1'b1, 8'd45, 0);

        // response backpressure
        do_cmd(1'b1, 8'd35, 5);

        // fill to capacity, then a rejected insert
        do_reset();
        for (int k = 1; k <= 16; k++) do_cmd(1'b0, 8'(k), 0);
        chk("full_after_16", 32'(full), 32'd1);
        do_cmd(1'b0, 8'd99, 0);
        chk("count_stays_16", 32'(entry_count), 32'd16);

        // stale CAM contents masked after reset
        do_reset();
        do_cmd(1'b0, 8'd4, 0);
        do_reset();
        do_cmd(1'b1, 8'd4, 0);

        // rst while in WAIT drops the response
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 1'b1; bus.cmd_key = 8'd4;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("read_ren", 32'({cam_ren, cam_din}), 32'({1'b1, 8'd4}));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("wait_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("wait_rst_ready", 32'(bus.cmd_ready), 32'd0);
        rst = 1'b0;
        model_cnt = 0;
        @(negedge clk);
        chk("wait_rst_ready_after", 32'(bus.cmd_ready), 32'd1);
        chk("wait_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);

        // rst while in WRITE: the write lands in the CAM but the count is cleared
        begin
            int wen0;
            logic [11:0] last_wr;
            wen0 = wen_log.size();
            bus.cmd_valid = 1'b1; bus.cmd_op = 1'b0; bus.cmd_key = 8'h77;
            @(posedge clk);
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            rst = 1'b1;
            model_mem[0] = 8'h77;
            model_wr[0]  = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            model_cnt = 0;
            @(negedge clk);
            chk("write_rst_pulse", 32'(wen_log.size() - wen0), 32'd1);
            last_wr = wen_log[wen_log.size() - 1];
            chk("write_rst_cam", 32'(last_wr), 32'({4'd0, 8'h77}));
            chk("write_rst_count", 32'(entry_count), 32'd0);
            chk("write_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            $display("insert key=119 interrupted by rst in WRITE");
        end
        do_cmd(1'b1, 8'h77, 0);

        // randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 90; n++) begin
            if ($urandom_range(0, 29) == 0) do_reset();
            rop  = ($urandom_range(0, 2) == 0);
            rkey = 8'($urandom_range(0, 9));
            do_cmd(rop, rkey, int'($urandom_range(0, 2)));
        end

        chk("wen_ren_exclusive", 32'(both_seen), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
